// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam logic [1:0] WORD_MASK = 2'b00;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant selection: data wins unless fetch has waited through STARVE_MAX data grants.
module mem_arb_prio #(
  parameter int SW         = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic          i_req,
  input  logic          d_req,
  input  logic [SW-1:0] starve_cnt,
  input  logic          can_grant,
  output logic          i_sel,
  output logic          d_sel
);

  logic starved;

  assign starved = (starve_cnt == SW'(STARVE_MAX));

  always_comb begin
    i_sel = 1'b0;
    d_sel = 1'b0;
    if (can_grant) begin
      if (d_req && !(i_req && starved)) d_sel = 1'b1;
      else if (i_req)                   i_sel = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch and load/store ports,
// sequencing a fixed read latency and returning a one-cycle valid pulse.
//
//   state | meaning
//   IDLE  | no outstanding access, grant allowed
//   BUSY  | access in flight, counting down MEM_LAT; grant allowed in response cycle
//   ERR   | one-cycle report of a misaligned data access, no grant
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_valid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_valid,
  output logic          d_err,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  localparam int LW = 3;
  localparam int SW = 4;

  state_t        state_q;
  owner_t        owner_q;
  logic          we_q;
  logic [LW-1:0] lat_q;
  logic [SW-1:0] starve_q;

  logic resp;
  logic can_grant;
  logic d_misal;
  logic unused_addr_bits;

  // The response cycle is the last BUSY cycle; the counter hits 0 at its end.
  assign resp      = (state_q == BUSY) && (lat_q == LW'(1));
  assign can_grant = reset && ((state_q == IDLE) || resp);
  assign d_misal   = (d_addr[1:0] != WORD_MASK);

  mem_arb_prio #(
    .SW         (SW),
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .i_req      (i_req),
    .d_req      (d_req),
    .starve_cnt (starve_q),
    .can_grant  (can_grant),
    .i_sel      (i_gnt),
    .d_sel      (d_gnt)
  );

  assign m_en    = i_gnt || (d_gnt && !d_misal);
  assign m_we    = d_gnt && !d_misal && d_we;
  assign m_addr  = i_gnt ? {i_addr[AW-1:2], WORD_MASK} : (m_en ? d_addr : '0);
  assign m_wdata = m_we ? d_wdata : '0;

  assign unused_addr_bits = ^i_addr[1:0];

  assign i_valid = reset && resp && (owner_q == OWN_I);
  assign d_valid = reset && ((resp && (owner_q == OWN_D)) || (state_q == ERR));
  assign d_err   = reset && (state_q == ERR);
  assign i_rdata = i_valid ? m_rdata : '0;
  assign d_rdata = (reset && resp && (owner_q == OWN_D) && !we_q) ? m_rdata : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= OWN_NONE;
      we_q     <= 1'b0;
      lat_q    <= '0;
      starve_q <= '0;
    end else begin
      if (!i_req || i_gnt)
        starve_q <= '0;
      else if (d_gnt && (starve_q < SW'(STARVE_MAX)))
        starve_q <= starve_q + SW'(1);

      if (i_gnt) begin
        state_q <= BUSY;
        owner_q <= OWN_I;
        we_q    <= 1'b0;
        lat_q   <= LW'(MEM_LAT);
      end else if (d_gnt) begin
        owner_q <= OWN_D;
        we_q    <= d_we;
        if (d_misal) begin
          state_q <= ERR;
          lat_q   <= '0;
        end else begin
          state_q <= BUSY;
          lat_q   <= LW'(MEM_LAT);
        end
      end else begin
        case (state_q)
          BUSY: begin
            lat_q <= lat_q - LW'(1);
            if (lat_q == LW'(1)) begin
              state_q <= IDLE;
              owner_q <= OWN_NONE;
              we_q    <= 1'b0;
            end
          end
          ERR: begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
            we_q    <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
          end
        endcase
      end
    end
  end

endmodule
